rx_packet_assembler: RTL

Receive-side store-and-forward packet buffer that sits directly downstream of the per-byte framing classifier. It consumes one byte per cycle together with the classifier's one-hot type code and TLP/DLLP tag, strips framing tokens, and buffers payload bytes. It commits only cleanly terminated packets to the data-link consumer as a valid/ready byte stream with sop/eop/kind markers. Nullified (EDB), malformed and overflowing packets are discarded in full and reported.

---
 rtl/rx_packet_assembler_if.sv | 27 ++
 rtl/rx_packet_assembler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_assembler_if.sv
// Byte-stream bus around the receive packet assembler: classifier-side input,
// consumer-side valid/ready output, and the discard report.
interface rx_packet_assembler_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic [5:0] in_type;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_dllp;
    logic       drop_pulse;
    logic [1:0] drop_cause;

    // Environment side: drives classifier bytes and consumer ready.
    modport master (
        output in_valid, in_data, in_type, out_ready,
        input  out_valid, out_data, out_sop, out_eop, out_dllp, drop_pulse, drop_cause
    );

    // Assembler side.
    modport slave (
        input  in_valid, in_data, in_type, out_ready,
        output out_valid, out_data, out_sop, out_eop, out_dllp, drop_pulse, drop_cause
    );
endinterface

// File: rtl/rx_packet_assembler.sv
// Store-and-forward receive packet buffer. Strips framing tokens, holds payload
// bytes until a clean end token commits the packet, and rewinds the write
// pointer to discard nullified, malformed or overflowing packets.
module rx_packet_assembler #(
    parameter int DEPTH    = 64,
    parameter int DLLP_LEN = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rx_packet_assembler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = 16;

    localparam logic [5:0] T_DATA  = 6'b100000;
    localparam logic [5:0] T_TLPS  = 6'b010000;
    localparam logic [5:0] T_TLPE  = 6'b001000;
    localparam logic [5:0] T_DLLPE = 6'b000100;
    localparam logic [5:0] T_DLLPS = 6'b000010;
    localparam logic [5:0] T_EDB   = 6'b000001;

    typedef enum logic [1:0] {ST_IDLE, ST_TLP, ST_DLLP} state_t;
    typedef enum logic [1:0] {
        CAUSE_EDB = 2'd0, CAUSE_OVF = 2'd1, CAUSE_LEN = 2'd2, CAUSE_RESTART = 2'd3
    } cause_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] commit_ptr, commit_ptr_nxt;
    logic [PW-1:0] pkt_start, pkt_start_nxt;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] len, len_nxt;
    logic          hold_valid, hold_valid_nxt;
    logic [7:0]    hold_data, hold_data_nxt;
    logic          ovf, ovf_nxt;
    logic          drop_pulse, drop_pulse_nxt;
    cause_t        drop_cause, drop_cause_nxt;
    logic          first_flag;

    // Entry layout: {kind, last, data}.
    logic [9:0]    mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [9:0]    mem_wdata;
    logic [9:0]    rd_data;

    logic          tok_data, tok_tlps, tok_tlpe, tok_dllpe, tok_dllps, tok_edb;
    logic          tok_start, tok_end;
    logic [PW-1:0] used;
    logic          room, end_ok, len_ok, commit_ok, pop;

    // Token decode and space/commit qualification.
    always_comb begin
        tok_data  = bus.in_valid && (bus.in_type == T_DATA);
        tok_tlps  = bus.in_valid && (bus.in_type == T_TLPS);
        tok_tlpe  = bus.in_valid && (bus.in_type == T_TLPE);
        tok_dllpe = bus.in_valid && (bus.in_type == T_DLLPE);
        tok_dllps = bus.in_valid && (bus.in_type == T_DLLPS);
        tok_edb   = bus.in_valid && (bus.in_type == T_EDB);
        tok_start = tok_tlps || tok_dllps;
        tok_end   = tok_tlpe || tok_dllpe;
        // Free-space check uses the pre-pop read pointer.
        used      = wr_ptr - rd_ptr;
        room      = (used != PW'(DEPTH));
        end_ok    = ((state == ST_TLP) && tok_tlpe) || ((state == ST_DLLP) && tok_dllpe);
        len_ok    = (len != '0) && ((state != ST_DLLP) || (len == LW'(DLLP_LEN)));
        commit_ok = end_ok && len_ok && !ovf && room;
    end

    // Write FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Write FSM next-state: a start token always opens a packet; end/edb close it.
    always_comb begin
        state_nxt = state;
        if (tok_tlps)
            state_nxt = ST_TLP;
        else if (tok_dllps)
            state_nxt = ST_DLLP;
        else if ((state != ST_IDLE) && (tok_end || tok_edb))
            state_nxt = ST_IDLE;
    end

    // Write FSM outputs: hold-register staging, buffer writes, commit and discard.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        pkt_start_nxt  = pkt_start;
        len_nxt        = len;
        hold_valid_nxt = hold_valid;
        hold_data_nxt  = hold_data;
        ovf_nxt        = ovf;
        drop_pulse_nxt = 1'b0;
        drop_cause_nxt = CAUSE_EDB;
        mem_we         = 1'b0;
        mem_waddr      = wr_ptr[AW-1:0];
        mem_wdata      = {state == ST_DLLP, 1'b0, hold_data};

        if (tok_start) begin
            if (state != ST_IDLE) begin
                drop_pulse_nxt = 1'b1;
                drop_cause_nxt = CAUSE_RESTART;
                wr_ptr_nxt     = pkt_start;
            end else begin
                pkt_start_nxt  = wr_ptr;
            end
            len_nxt        = '0;
            ovf_nxt        = 1'b0;
            hold_valid_nxt = 1'b0;
        end else if (state != ST_IDLE) begin
            if (tok_data) begin
                len_nxt = (len == '1) ? len : len + 1'b1;
                if (!hold_valid) begin
                    hold_valid_nxt = 1'b1;
                    hold_data_nxt  = bus.in_data;
                end else if (room && !ovf) begin
                    mem_we        = 1'b1;
                    wr_ptr_nxt    = wr_ptr + 1'b1;
                    hold_data_nxt = bus.in_data;
                end else begin
                    ovf_nxt = 1'b1;
                end
            end else if (tok_end || tok_edb) begin
                hold_valid_nxt = 1'b0;
                len_nxt        = '0;
                ovf_nxt        = 1'b0;
                if (tok_end && commit_ok) begin
                    mem_we         = 1'b1;
                    mem_wdata[8]   = 1'b1;
                    wr_ptr_nxt     = wr_ptr + 1'b1;
                    commit_ptr_nxt = wr_ptr + 1'b1;
                end else begin
                    wr_ptr_nxt     = pkt_start;
                    drop_pulse_nxt = 1'b1;
                    if (tok_edb)
                        drop_cause_nxt = CAUSE_EDB;
                    else if (ovf || (end_ok && len_ok))
                        drop_cause_nxt = CAUSE_OVF;
                    else
                        drop_cause_nxt = CAUSE_LEN;
                end
            end
        end
    end

    // Write-side datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_start  <= '0;
            len        <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            ovf        <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cause <= CAUSE_EDB;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            pkt_start  <= pkt_start_nxt;
            len        <= len_nxt;
            hold_valid <= hold_valid_nxt;
            hold_data  <= hold_data_nxt;
            ovf        <= ovf_nxt;
            drop_pulse <= drop_pulse_nxt;
            drop_cause <= drop_cause_nxt;
        end
    end

    // Packet buffer storage.
    // NOTE: the array is not reset; pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read side: pop pointer and start-of-packet tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            first_flag <= 1'b1;
        end else if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            first_flag <= rd_data[8];
        end
    end

    // First-word fall-through output; fields forced low when nothing is committed.
    always_comb begin
        rd_data        = mem[rd_ptr[AW-1:0]];
        bus.out_valid  = (rd_ptr != commit_ptr);
        pop            = bus.out_valid && bus.out_ready;
        bus.out_data   = bus.out_valid ? rd_data[7:0] : 8'h00;
        bus.out_eop    = bus.out_valid && rd_data[8];
        bus.out_dllp   = bus.out_valid && rd_data[9];
        bus.out_sop    = bus.out_valid && first_flag;
        bus.drop_pulse = drop_pulse;
        bus.drop_cause = drop_cause;
    end
endmodule
